// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Scan controller for a 4-digit common-anode 7-segment display. It keeps a
// double-buffered store of four digits (4-bit hex nibble + decimal point) and
// time-multiplexes them onto one shared segment decoder and four active-low
// anodes. Each digit slot opens with a dark guard interval to stop ghosting.
// Writes go to a shadow bank. The shadow bank is copied to the active
// (displayed) bank only at a frame boundary, so a multi-digit update never
// shows a torn value.
//
// Parameters
//   CLK_DIV      clock cycles per digit slot (4 .. 2**20)
//   GUARD        dark cycles at the start of each slot (1 <= GUARD < CLK_DIV)
//
// Optional feature
//   SEG7_LZ_BLANK_EN  when defined, leading-zero digits 3..1 are blanked.
//                     A digit counts as a leading zero only if it and every
//                     higher digit have data = 0 and dp = 0.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   wr_en        write strobe into the shadow bank
//   wr_addr      shadow digit index (0 = rightmost)
//   wr_data      hex nibble to store
//   wr_dp        decimal point for that digit (1 = lit)
//   commit       request to copy shadow -> active at the next frame end
//   digit_en     live per-digit enable mask (0 = digit forced dark)
//   bin          nibble of the current digit, to the segment decoder
//   an           anodes, active-low, at most one low at a time
//   dp_n         decimal point, active-low
//   digit_idx    current slot index
//   commit_busy  commit requested but not yet applied
//   frame_done   one-cycle pulse after the slot index wraps 3 -> 0
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int unsigned CLK_DIV = 25000,
  parameter int unsigned GUARD   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       commit,
  input  logic [3:0] digit_en,
  output logic [3:0] bin,
  output logic [3:0] an,
  output logic       dp_n,
  output logic [1:0] digit_idx,
  output logic       commit_busy,
  output logic       frame_done
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  typedef struct packed {
    logic [3:0] data;
    logic       dp;
  } digit_t;

  typedef enum logic {
    PH_GUARD,
    PH_SHOW
  } phase_e;

  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [1:0]    idx_q, idx_nxt;
  logic          pend_q, pend_nxt;
  logic          slot_end, wrap, xfer;
  phase_e        phase_nxt;
  digit_t [3:0]  shadow_q, active_q, active_nxt;
  logic [3:0]    blank;
  logic          lit_nxt;

  logic [3:0]    an_q;
  logic          dp_q;
  logic [3:0]    bin_q;
  logic          fd_q;

`ifdef SEG7_LZ_BLANK_EN
  logic          zero_above;
`endif

  // Everything registered is computed from the post-edge counter state
  // (cnt_nxt/idx_nxt/active_nxt), so the outputs line up with the counter
  // after the same edge instead of trailing it by a cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    slot_end   = (cnt_q == CW'(CLK_DIV - 1));
    wrap       = slot_end && (idx_q == 2'd3);
    cnt_nxt    = slot_end ? '0 : cnt_q + 1'b1;
    idx_nxt    = slot_end ? idx_q + 2'd1 : idx_q;
    // A commit arriving on the frame-end edge itself is honoured at once.
    xfer       = wrap && (pend_q || commit);
    active_nxt = xfer ? shadow_q : active_q;
    pend_nxt   = wrap ? 1'b0 : (pend_q | commit);
    phase_nxt  = (cnt_nxt < CW'(GUARD)) ? PH_GUARD : PH_SHOW;

    blank = '0;
`ifdef SEG7_LZ_BLANK_EN
    // Walk down from the top digit. A digit is blanked while it and all
    // digits above it are completely empty. Digit 0 is never blanked.
    zero_above = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      zero_above = zero_above && (active_nxt[i] == '0);
      blank[i]   = zero_above;
    end
`endif

    lit_nxt = (phase_nxt == PH_SHOW) && !blank[idx_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      // NOTE: both digit banks are reset explicitly. A display must come up
      // blank/zero and not show power-on garbage.
      shadow_q <= '0;
      active_q <= '0;
      an_q     <= 4'hF;
      dp_q     <= 1'b1;
      bin_q    <= '0;
      fd_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. This makes
      // the active bank take the pre-write shadow on a write+commit edge.
      cnt_q    <= cnt_nxt;
      idx_q    <= idx_nxt;
      pend_q   <= pend_nxt;
      active_q <= active_nxt;
      if (wr_en) shadow_q[wr_addr] <= {wr_data, wr_dp};
      an_q     <= lit_nxt ? ~(4'b0001 << idx_nxt) : 4'hF;
      dp_q     <= lit_nxt ? ~active_nxt[idx_nxt].dp : 1'b1;
      bin_q    <= active_nxt[idx_nxt].data;
      fd_q     <= wrap;
    end
  end

  // The digit_en mask is applied after the registers so that mask changes
  // reach the anodes in the same cycle.
  assign an          = an_q | ~digit_en;
  assign dp_n        = dp_q | ~digit_en[idx_q];
  assign bin         = bin_q;
  assign digit_idx   = idx_q;
  assign commit_busy = pend_q;
  assign frame_done  = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Scoreboard bench for seg7_scan_ctrl with CLK_DIV=8 and GUARD=2.
// The reference model tracks elapsed edges since reset, a shadow array, an
// active array and a pending flag. From these it derives the slot index, the
// phase and the expected outputs with plain arithmetic. The driver pushes
// one expected output set per cycle. The monitor pops each set and compares
// it on the falling edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int CLK_DIV = 8;
  localparam int GUARD   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       commit;
  logic [3:0] digit_en;
  logic [3:0] bin;
  logic [3:0] an;
  logic       dp_n;
  logic [1:0] digit_idx;
  logic       commit_busy;
  logic       frame_done;

  seg7_scan_ctrl #(.CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .commit     (commit),
    .digit_en   (digit_en),
    .bin        (bin),
    .an         (an),
    .dp_n       (dp_n),
    .digit_idx  (digit_idx),
    .commit_busy(commit_busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic       dp_n;
    logic [3:0] bin;
    logic [1:0] idx;
    logic       fd;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   running = 0;

  // Reference model state.
  int         t;
  logic [3:0] sh_d[4];
  logic       sh_p[4];
  logic [3:0] ac_d[4];
  logic       ac_p[4];
  bit         pend;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    t    = 0;
    pend = 0;
    for (int i = 0; i < 4; i++) begin
      sh_d[i] = '0; sh_p[i] = 0; ac_d[i] = '0; ac_p[i] = 0;
    end
  endfunction

  // One rising edge with the inputs as currently driven.
  function automatic void model_edge();
    if ((t % FRAME) == FRAME - 1) begin
      if (pend || commit)
        for (int i = 0; i < 4; i++) begin
          ac_d[i] = sh_d[i];
          ac_p[i] = sh_p[i];
        end
      pend = 0;
    end else if (commit) begin
      pend = 1;
    end
    if (wr_en) begin
      sh_d[wr_addr] = wr_data;
      sh_p[wr_addr] = wr_dp;
    end
    t++;
  endfunction

  function automatic bit lz_dark(input int i);
    bit dark = 0;
`ifdef SEG7_LZ_BLANK_EN
    if (i != 0) begin
      dark = 1;
      for (int j = i; j < 4; j++)
        if (ac_d[j] != 0 || ac_p[j]) dark = 0;
    end
`endif
    return dark;
  endfunction

  function automatic exp_t expected();
    exp_t e;
    int   cnt = t % CLK_DIV;
    int   idx = (t / CLK_DIV) % 4;
    bit   lit = (cnt >= GUARD) && digit_en[idx] && !lz_dark(idx);
    e.an   = lit ? (4'hF & ~(4'b0001 << idx)) : 4'hF;
    e.dp_n = lit ? ~ac_p[idx] : 1'b1;
    e.bin  = ac_d[idx];
    e.idx  = 2'(idx);
    e.fd   = (t > 0) && ((t % FRAME) == 0);
    e.busy = pend;
    return e;
  endfunction

  // Drive one cycle of inputs, queue the expected outputs for that cycle,
  // then advance the model over the next rising edge.
  task automatic step(input bit we, input logic [1:0] a, input logic [3:0] d,
                      input bit p, input bit cm, input logic [3:0] en);
    wr_en = we; wr_addr = a; wr_data = d; wr_dp = p; commit = cm; digit_en = en;
    running = 1;
    exp_q.push_back(expected());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] en);
    for (int i = 0; i < n; i++) step(0, 2'd0, 4'd0, 0, 0, en);
  endtask

  task automatic idle_until_phase(input int ph);
    int guard_cnt = 0;
    while ((t % FRAME) != ph && guard_cnt < 2 * FRAME) begin
      step(0, 2'd0, 4'd0, 0, 0, 4'hF);
      guard_cnt++;
    end
  endtask

  task automatic rand_step();
    logic [3:0] en;
    en = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
    step($urandom_range(0, 1) == 1, 2'($urandom), 4'($urandom),
         $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, en);
  endtask

  // Assert reset between edges and hold it for n cycles. The outputs must
  // drop to reset values before the next falling edge.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      running = 1;
      exp_q.push_back(expected());
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (running || exp_q.size() > 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("an",          8'(an),          8'(e.an));
        check("dp_n",        8'(dp_n),        8'(e.dp_n));
        check("bin",         8'(bin),         8'(e.bin));
        check("digit_idx",   8'(digit_idx),   8'(e.idx));
        check("frame_done",  8'(frame_done),  8'(e.fd));
        check("commit_busy", 8'(commit_busy), 8'(e.busy));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_dp = 0;
    commit = 0; digit_en = 4'hF;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(3);

    // Reset, scan sequence, write {3:A,2:5,1:0,0:F} and commit at cycle 5.
    step(0, 2'd0, 4'h0, 0, 0, 4'hF);
    step(1, 2'd3, 4'hA, 0, 0, 4'hF);
    step(1, 2'd2, 4'h5, 1, 0, 4'hF);
    step(1, 2'd1, 4'h0, 0, 0, 4'hF);
    step(1, 2'd0, 4'hF, 0, 0, 4'hF);
    step(0, 2'd0, 4'h0, 0, 1, 4'hF);
    idle(3 * FRAME, 4'hF);

    // Write + commit on the same frame-end edge, with digit0 = 3 written earlier.
    step(1, 2'd0, 4'h3, 0, 0, 4'hF);
    idle_until_phase(FRAME - 1);
    step(1, 2'd0, 4'h7, 0, 1, 4'hF);
    idle(4, 4'hF);
    step(0, 2'd0, 4'h0, 0, 1, 4'hF);
    idle(2 * FRAME, 4'hF);

    // Mask: only digits 0 and 2 enabled.
    idle(FRAME + 5, 4'b0101);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) rand_step();
    idle(FRAME, 4'hF);

    // Reset at cycle 13 while a commit is pending.
    do_reset(2);
    step(0, 2'd0, 4'h0, 0, 0, 4'hF);
    for (int i = 0; i < 4; i++) step(1, 2'(i), 4'(i + 9), 1, 0, 4'hF);
    step(0, 2'd0, 4'h0, 0, 1, 4'hF);
    idle(7, 4'hF);
    do_reset(2);
    idle(2 * FRAME + 3, 4'hF);

    // Leading-zero cases: {0,0,4,2} and then all zeros.
    step(1, 2'd3, 4'h0, 0, 0, 4'hF);
    step(1, 2'd2, 4'h0, 0, 0, 4'hF);
    step(1, 2'd1, 4'h4, 0, 0, 4'hF);
    step(1, 2'd0, 4'h2, 0, 1, 4'hF);
    idle(2 * FRAME, 4'hF);
    step(1, 2'd1, 4'h0, 0, 0, 4'hF);
    step(1, 2'd0, 4'h0, 0, 1, 4'hF);
    idle(2 * FRAME, 4'hF);

    running = 0;
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing scan controller for the board's 4-digit common-anode 7-segment display. Holds a double-buffered 4×(4-bit hex + decimal point) digit store and cycles through the digits. For each digit it presents the nibble on `bin`, which feeds the `binary_to_segment` decoder, and drives the matching active-low anode. A guard interval between digits prevents ghosting. Writes are made tear-free by committing the shadow bank only at frame boundaries.

## Interface
- `CLK_DIV`, 25000, clock cycles per digit slot (4 kHz slot / 1 kHz frame at 100 MHz); legal range 4..2^20.
- `GUARD`, 500, cycles at the start of each slot with all anodes off; 1 ≤ GUARD < CLK_DIV.
- `clk` input 1 system clock; all state on rising edge.
- `rst_n` input 1 asynchronous, active-low reset.
- `wr_en` input 1 write strobe into the shadow bank.
- `wr_addr` input 2 shadow digit index (0 = rightmost).
- `wr_data` input 4 hex nibble to store.
- `wr_dp` input 1 decimal point for that digit (1 = lit).
- `commit` input 1 single-cycle request to copy shadow → active at next frame end.
- `digit_en` input 4 per-digit enable mask, live (unregistered path into anode logic); 0 = digit forced dark.
- `bin` output 4 active nibble of the current digit, to `binary_to_segment`.
- `an` output 4 anodes, active-low, at most one low at a time.
- `dp_n` output 1 decimal point, active-low.
- `digit_idx` output 2 current slot index.
- `commit_busy` output 1 commit pending, not yet applied.
- `frame_done` output 1 one-cycle pulse on the edge the slot index wraps 3→0.

## Operation
- **Prescaler `cnt`.** Counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it returns to 0 and `digit_idx` advances modulo 4 (3→0 wraps).
- **Per-slot states.**
  - GUARD (cnt < GUARD): `an` = 4'b1111, `dp_n` = 1.
  - SHOW (cnt ≥ GUARD): `an[digit_idx]` = 0, unless the digit is suppressed.
  - A suppressed digit has `digit_en[digit_idx]` = 0 or is leading-zero blanked (see Configuration). It keeps all anodes high and `dp_n` = 1.
- **`bin` and `dp_n`.** `bin` = active[digit_idx].data in both states. In SHOW, `dp_n` = ~active[digit_idx].dp.
- **Writes.**
  - A `wr_en` cycle updates shadow[wr_addr] on that edge. There is no backpressure; writes are accepted every cycle.
  - Writing does not affect the display until committed.
- **Commit.**
  - `commit` sets the pending flag; `commit_busy` = flag.
  - On the frame-end edge (`digit_idx` 3→0), if the flag is set or `commit` is high that same cycle: active ← shadow, and the flag clears.
  - Repeated `commit` while pending is idempotent.
- **Simultaneous events.**
  - A write on the frame-end edge lands in shadow only. The active bank receives the pre-write shadow contents, and the new data needs another commit.
  - `commit` and frame end on the same edge: the transfer happens at that edge, `commit_busy` stays 0, and the flag is not left set.
- **Reset (any time, including mid-slot or while a commit is pending).**
  - `cnt` = 0, `digit_idx` = 0.
  - Shadow and active banks = 0, dp = 0, pending flag = 0.
  - Outputs: `an` = 4'b1111, `dp_n` = 1, `bin` = 0, `frame_done` = 0, `commit_busy` = 0.

## Timing
- `an`, `dp_n`, `bin`, `digit_idx`, `frame_done` and `commit_busy` are registered. Each reflects the counter state after the same edge, with no extra pipeline lag.
- Edge 1 is the first rising edge after `rst_n` deasserts. After edge n, `cnt` = n mod CLK_DIV.
  - Slot 0 is dark for edges 0..GUARD-1 (including the reset state).
  - `an` = 4'b1110 from edge GUARD through edge CLK_DIV-1.
- Slot length is exactly CLK_DIV cycles and frame length is exactly 4·CLK_DIV cycles.
- `frame_done` is high for the single cycle following the wrap edge. The new active data is on `bin` in that same cycle.
- Commit latency runs from the `commit` edge to the frame-end edge: between 0 and 4·CLK_DIV-1 cycles.
- `digit_en` changes take effect combinationally on `an` in the same cycle.

## Configuration
- Macro: `SEG7_LZ_BLANK_EN`.
- **Defined:** digit i (i = 3,2,1) is leading-zero blanked when active[i..3].data are all 0 and active[i..3].dp are all 0. Digit 0 is never blanked, so value 0 shows as a single "0".
- **Undefined:** no leading-zero logic; all enabled digits are shown, including zeros.

## Test plan
Bench parameters: CLK_DIV=8, GUARD=2.
- **Reset/scan.** Release reset with all digits enabled.
  - `an` sequence: 1111 for cnt 0–1, 1110 for cnt 2–7.
  - Then 1111/1101, 1111/1011, 1111/0111 in turn.
  - `frame_done` pulses at cycle 32; period is 32 cycles.
- **Write + commit.** Write shadow = {3:A, 2:5, 1:0, 0:F}, then pulse `commit` at cycle 5.
  - `commit_busy` = 1 until cycle 32.
  - From cycle 32, `bin` reads F,0,5,A in slots 0..3.
  - Before cycle 32, `bin` = 0 throughout.
- **Simultaneous events.** `commit` and a write of digit0=7 on the frame-end edge, with prior shadow digit0=3.
  - Active digit0 = 3 and `commit_busy` = 0.
  - A second commit yields 7 one frame later.
- **Mask.** `digit_en` = 4'b0101.
  - Slots 1 and 3 keep `an` = 1111 and `dp_n` = 1.
  - Slots 0 and 2 are normal.
- **Reset mid-operation.** Assert `rst_n`=0 at cycle 13 with a commit pending.
  - Outputs return to reset values immediately (asynchronous), and `commit_busy` = 0.
  - After release, the active bank is all zero.
- **`SEG7_LZ_BLANK_EN`.** Active = {0,0,4,2}: digits 3 and 2 dark, digits 1 and 0 lit.
  - All-zero active bank: only digit 0 is lit.
  - With the macro undefined: all four are lit.
